// File: rtl/reg_writeback.sv
// Result writeback queue: FIFO of results drained up to two per cycle into register-file,
// R15/pc and cspr write ports. Define WB_BYPASS_EN to add newest-pending-data forwarding.
module reg_writeback #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [3:0]                 res_addr,
  input  logic [N-1:0]               res_data,
  input  logic                       res_flags_valid,
  input  logic [N-1:0]               res_flags,
  output logic [3:0]                 write_address,
  output logic [N-1:0]               write_data,
  output logic                       write_enable,
  output logic [3:0]                 write_address_2,
  output logic [N-1:0]               write_data_2,
  output logic                       write_enable_2,
  output logic [N-1:0]               pc_update,
  output logic                       pc_write,
  output logic [N-1:0]               cspr_update,
  output logic                       cspr_write,
  input  logic [3:0]                 pend_addr,
  output logic                       pend_hit,
  output logic                       byp_hit,
  output logic [N-1:0]               byp_data,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]   q_addr  [DEPTH];
  logic [N-1:0] q_data  [DEPTH];
  logic         q_fv    [DEPTH];
  logic [N-1:0] q_flags [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_1;
  logic          push, take0, take1, conflict;
  logic [AW:0]   drained;

  assign res_ready = (occupancy < (AW+1)'(DEPTH));
  assign push      = res_valid && res_ready;

  always_comb begin
    rd_ptr_1 = rd_ptr + 1'b1;
    // Same-register, double-pc and double-flag pairs would race in the register file.
    conflict = (q_addr[rd_ptr] == q_addr[rd_ptr_1]) ||
               (q_addr[rd_ptr] == 4'd15 && q_addr[rd_ptr_1] == 4'd15) ||
               (q_fv[rd_ptr] && q_fv[rd_ptr_1]);
    take0    = (occupancy != '0);
    take1    = (occupancy >= (AW+1)'(2)) && !conflict;
    drained  = (AW+1)'(take0) + (AW+1)'(take1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= res_addr;
      q_data[wr_ptr]  <= res_data;
      q_fv[wr_ptr]    <= res_flags_valid;
      q_flags[wr_ptr] <= res_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      occupancy       <= '0;
      write_address   <= '0;
      write_data      <= '0;
      write_enable    <= 1'b0;
      write_address_2 <= '0;
      write_data_2    <= '0;
      write_enable_2  <= 1'b0;
      pc_update       <= '0;
      pc_write        <= 1'b0;
      cspr_update     <= '0;
      cspr_write      <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr + drained[AW-1:0];
      wr_ptr    <= wr_ptr + AW'(push);
      occupancy <= occupancy + (AW+1)'(push) - drained;

      write_enable    <= take0 && q_addr[rd_ptr] != 4'd15;
      write_address   <= (take0 && q_addr[rd_ptr] != 4'd15) ? q_addr[rd_ptr] : '0;
      write_data      <= (take0 && q_addr[rd_ptr] != 4'd15) ? q_data[rd_ptr] : '0;
      write_enable_2  <= take1 && q_addr[rd_ptr_1] != 4'd15;
      write_address_2 <= (take1 && q_addr[rd_ptr_1] != 4'd15) ? q_addr[rd_ptr_1] : '0;
      write_data_2    <= (take1 && q_addr[rd_ptr_1] != 4'd15) ? q_data[rd_ptr_1] : '0;

      pc_write  <= 1'b0;
      pc_update <= '0;
      if (take0 && q_addr[rd_ptr] == 4'd15) begin
        pc_write  <= 1'b1;
        pc_update <= q_data[rd_ptr];
      end else if (take1 && q_addr[rd_ptr_1] == 4'd15) begin
        pc_write  <= 1'b1;
        pc_update <= q_data[rd_ptr_1];
      end

      cspr_write  <= 1'b0;
      cspr_update <= '0;
      if (take0 && q_fv[rd_ptr]) begin
        cspr_write  <= 1'b1;
        cspr_update <= q_flags[rd_ptr];
      end else if (take1 && q_fv[rd_ptr_1]) begin
        cspr_write  <= 1'b1;
        cspr_update <= q_flags[rd_ptr_1];
      end
    end
  end

  always_comb begin
    pend_hit = (write_enable && write_address == pend_addr) ||
               (write_enable_2 && write_address_2 == pend_addr) ||
               (pc_write && pend_addr == 4'd15);
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < occupancy && q_addr[rd_ptr + AW'(i)] == pend_addr)
        pend_hit = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Outputs are older than anything still queued; scan oldest to newest so the last match wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (write_enable && write_address == pend_addr) begin
      byp_hit  = 1'b1;
      byp_data = write_data;
    end
    if (write_enable_2 && write_address_2 == pend_addr) begin
      byp_hit  = 1'b1;
      byp_data = write_data_2;
    end
    if (pc_write && pend_addr == 4'd15) begin
      byp_hit  = 1'b1;
      byp_data = pc_update;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < occupancy && q_addr[rd_ptr + AW'(i)] == pend_addr) begin
        byp_hit  = 1'b1;
        byp_data = q_data[rd_ptr + AW'(i)];
      end
    end
  end
`else
  assign byp_hit  = 1'b0;
  assign byp_data = '0;
`endif
endmodule
